bram_wr_arbiter: RTL and testbench
==================================

// Module: bram_wr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing the single label-BRAM write port among NUM_REQ masked-word writers.
//  Each writer presents a level request with a pre-masked address/data word and holds it until o_done[k].
//  Drives the BRAM write trig/addr/data handshake, one write in flight at a time, and reports completion per requester.
// PARAMETERS
//  NUM_REQ      4    number of requesters (2..8)
//  ADDR_W       13   BRAM word address width
//  DATA_W       32   BRAM word width
//  TIMEOUT_CYC  255  ack wait limit in cycles (used only with BRAM_WR_ARB_TIMEOUT_EN; 1..65535)
// PORTS
//  i_clk            in   1               clock; all logic on rising edge
//  i_rst            in   1               reset, synchronous, active-high
//  i_req            in   NUM_REQ         level write request per requester
//  i_req_addr       in   NUM_REQ*ADDR_W  packed addresses; requester k at [k*ADDR_W +: ADDR_W]
//  i_req_data       in   NUM_REQ*DATA_W  packed data; requester k at [k*DATA_W +: DATA_W]
//  o_done           out  NUM_REQ         one-cycle completion pulse per requester
//  o_wr_bram_addr   out  ADDR_W          BRAM write address
//  o_wr_bram_data   out  DATA_W          BRAM write data
//  o_wr_bram_trig   out  1               BRAM write strobe, held until ack
//  i_wr_bram_ack    in   1               BRAM write acknowledge
//  o_busy           out  1               high whenever state != IDLE
//  o_grant_id       out  3               index of current/last granted requester
//  o_timeout_err    out  1               sticky ack-timeout flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; last-grant pointer = NUM_REQ-1, so requester 0 wins first.
//  All outputs registered; no combinational path from any input to any output.
//  States: IDLE -> ISSUE -> GAP -> IDLE.
//  IDLE: if |i_req, grant first set bit searching from (last+1) mod NUM_REQ upward with wrap.
//   Latch that requester's addr/data into outputs, set trig=1, o_grant_id=k, go ISSUE. Latency req->trig = 1 cycle.
//  ISSUE: trig/addr/data held stable. On the first edge with i_wr_bram_ack=1, next cycle: trig=0, addr/data=0, o_done[k]=1 (one cycle), last=k, go GAP.
//   Ack may already be high on the first ISSUE cycle; that yields a one-cycle trig.
//  GAP: one guard cycle; all i_req ignored. Requester must drop i_req[k] by the cycle after o_done[k]. Then IDLE.
//  Back-to-back: same requester re-requesting is served again only if no other request is pending (fairness).
//  Min throughput: 1 write per 3 cycles (IDLE, ISSUE, GAP).
//  Ack while IDLE or GAP: ignored, no effect.
//  i_req[k] dropped during ISSUE: write is already committed; it completes and o_done[k] still pulses.
//  Changes to i_req_addr/data after grant: ignored until the next grant.
//  Reset mid-ISSUE: trig drops on the next edge, no o_done pulse; the write is considered aborted.
//  o_grant_id is zero-extended to 3 bits and retains its last value in IDLE.
// CONFIGURATION
//  BRAM_WR_ARB_TIMEOUT_EN defined:
//   16-bit counter cleared on ISSUE entry, increments each ISSUE cycle without ack.
//   Count reaching TIMEOUT_CYC: trig drops, o_done[k] pulses (aborted write), o_timeout_err set sticky until i_rst, go GAP.
//   Ack on the same edge the count reaches TIMEOUT_CYC is treated as success; err not set.
//  BRAM_WR_ARB_TIMEOUT_EN undefined: no counter, ISSUE waits for ack indefinitely, o_timeout_err tied 0 (port still present).
// TESTING
//  1 Reset then single req[2], addr=0x0A5, data=0xDEADBEEF, ack 2 cycles after trig ->
//    trig 1 cycle after req, held 3 cycles with stable addr/data, o_done=4'b0100 for 1 cycle, grant_id=2.
//  2 req=4'b1111 held, each requester drops after its done, ack immediate -> grant order 0,1,2,3; trig period 3 cycles.
//  3 After grant 1, req=4'b0011 persistent with drop/reassert -> next grants 0 then 1 (wrap fairness), no starvation.
//  4 i_rst asserted while trig high with req[3] -> next cycle trig=0, done=0, busy=0; next req 0/3 pair grants 0.
//  5 Ack pulsed in IDLE, req[1] dropped mid-ISSUE -> idle ack ignored; req[1] write still completes with o_done[1].
//  6 TIMEOUT_EN, TIMEOUT_CYC=8, ack never -> trig high exactly 8 cycles, o_done[k] pulse, o_timeout_err=1 until reset;
//    without the macro, trig stays high and err stays 0.

Source files
------------

// File: rtl/bram_wr_arbiter.sv
// Round-robin sequencer that shares one BRAM write port among NUM_REQ requesters, one write in flight at a time.
// Optional ack watchdog enabled by defining BRAM_WR_ARB_TIMEOUT_EN (TIMEOUT_CYC cycles without ack aborts the write).
module bram_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_done,
    output logic [ADDR_W-1:0]         o_wr_bram_addr,
    output logic [DATA_W-1:0]         o_wr_bram_data,
    output logic                      o_wr_bram_trig,
    input  logic                      i_wr_bram_ack,
    output logic                      o_busy,
    output logic [2:0]                o_grant_id,
    output logic                      o_timeout_err
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CAND_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   cur;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CAND_W-1:0]  cand;
    logic               write_end;

    // Round-robin search starting just after the last completed requester.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = CAND_W'(last) + CAND_W'(i) + CAND_W'(1);
            if (cand >= CAND_W'(NUM_REQ))
                cand = cand - CAND_W'(NUM_REQ);
            if (!pick_valid && i_req[cand[IDX_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

`ifdef BRAM_WR_ARB_TIMEOUT_EN
    logic [15:0] ack_wait;
    logic        timeout_hit;

    // An ack arriving on the limit edge wins over the timeout.
    assign timeout_hit = (state == ISSUE) && !i_wr_bram_ack &&
                         (ack_wait == 16'(TIMEOUT_CYC - 1));
    assign write_end   = i_wr_bram_ack || timeout_hit;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ack_wait      <= '0;
            o_timeout_err <= 1'b0;
        end else begin
            if (state != ISSUE)
                ack_wait <= '0;
            else if (!i_wr_bram_ack)
                ack_wait <= ack_wait + 16'd1;
            if (timeout_hit)
                o_timeout_err <= 1'b1;
        end
    end
`else
    assign write_end     = i_wr_bram_ack;
    assign o_timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            last           <= IDX_W'(NUM_REQ - 1);
            cur            <= '0;
            o_done         <= '0;
            o_wr_bram_addr <= '0;
            o_wr_bram_data <= '0;
            o_wr_bram_trig <= 1'b0;
            o_busy         <= 1'b0;
            o_grant_id     <= '0;
        end else begin
            o_done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cur            <= pick_idx;
                        o_grant_id     <= 3'(pick_idx);
                        o_wr_bram_addr <= i_req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        o_wr_bram_data <= i_req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        o_wr_bram_trig <= 1'b1;
                        o_busy         <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (write_end) begin
                        o_wr_bram_trig <= 1'b0;
                        o_wr_bram_addr <= '0;
                        o_wr_bram_data <= '0;
                        o_done[cur]    <= 1'b1;
                        last           <= cur;
                        state          <= GAP;
                    end
                end
                GAP: begin
                    // Guard cycle gives the finished requester time to drop its request.
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_wr_arbiter.sv
// Directed bench for bram_wr_arbiter: reset, single write, round-robin order, fairness, reset abort, idle ack, timeout.
module tb_bram_wr_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int ADDR_W      = 13;
    localparam int DATA_W      = 32;
    localparam int TIMEOUT_CYC = 8;

    logic                      i_clk = 1'b0;
    logic                      i_rst;
    logic [NUM_REQ-1:0]        i_req;
    logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
    logic [NUM_REQ*DATA_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        o_done;
    logic [ADDR_W-1:0]         o_wr_bram_addr;
    logic [DATA_W-1:0]         o_wr_bram_data;
    logic                      o_wr_bram_trig;
    logic                      i_wr_bram_ack;
    logic                      o_busy;
    logic [2:0]                o_grant_id;
    logic                      o_timeout_err;

    int checks = 0;
    int errors = 0;

    bram_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .o_done        (o_done),
        .o_wr_bram_addr(o_wr_bram_addr),
        .o_wr_bram_data(o_wr_bram_data),
        .o_wr_bram_trig(o_wr_bram_trig),
        .i_wr_bram_ack (i_wr_bram_ack),
        .o_busy        (o_busy),
        .o_grant_id    (o_grant_id),
        .o_timeout_err (o_timeout_err)
    );

    always #5 i_clk = ~i_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic set_word(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        i_req_addr[k*ADDR_W +: ADDR_W] = a;
        i_req_data[k*DATA_W +: DATA_W] = d;
    endtask

    // Requester k presents address 0x100+k and data 0xA0000000+k.
    task automatic init_words();
        for (int k = 0; k < NUM_REQ; k++)
            set_word(k, 13'h100 + 13'(k), 32'hA000_0000 + 32'(k));
    endtask

    task automatic do_reset();
        i_rst         = 1'b1;
        i_req         = '0;
        i_wr_bram_ack = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    // One full write with ack held high: grant, done pulse, back in IDLE; requester k drops on its done.
    task automatic serve(input int k);
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        ea = 13'h100 + 13'(k);
        ed = 32'hA000_0000 + 32'(k);
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b1 || o_grant_id !== 3'(k)) begin
            errors++;
            $display("FAIL serve_grant: trig=%0b grant=%0d, expected trig=1 grant=%0d", o_wr_bram_trig, o_grant_id, k);
        end
        checks++;
        if (o_wr_bram_addr !== ea || o_wr_bram_data !== ed) begin
            errors++;
            $display("FAIL serve_word: addr=%0h data=%0h, expected addr=%0h data=%0h", o_wr_bram_addr, o_wr_bram_data, ea, ed);
        end
        tick();
        checks++;
        if (o_done !== 4'(1 << k) || o_wr_bram_trig !== 1'b0) begin
            errors++;
            $display("FAIL serve_done: done=%b trig=%0b, expected done=%b trig=0", o_done, o_wr_bram_trig, 4'(1 << k));
        end
        i_req[k] = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b0 || o_done !== 4'b0000 || o_wr_bram_trig !== 1'b0) begin
            errors++;
            $display("FAIL serve_idle: busy=%0b done=%b trig=%0b, expected all 0", o_busy, o_done, o_wr_bram_trig);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_wr_bram_trig !== 1'b0 || o_busy !== 1'b0 || o_done !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: trig=%0b busy=%0b done=%b, expected 0 0 0000", o_wr_bram_trig, o_busy, o_done);
        end
        checks++;
        if (o_wr_bram_addr !== '0 || o_wr_bram_data !== '0 || o_grant_id !== 3'd0 || o_timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: addr=%0h data=%0h grant=%0d err=%0b, expected all 0",
                     o_wr_bram_addr, o_wr_bram_data, o_grant_id, o_timeout_err);
        end
    endtask

    task automatic test_single_write();
        set_word(2, 13'h0A5, 32'hDEAD_BEEF);
        i_req = 4'b0100;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b1 || o_busy !== 1'b1 || o_grant_id !== 3'd2 || o_done !== 4'b0000) begin
            errors++;
            $display("FAIL single_grant: trig=%0b busy=%0b grant=%0d done=%b, expected 1 1 2 0000",
                     o_wr_bram_trig, o_busy, o_grant_id, o_done);
        end
        set_word(2, 13'h1FF, 32'h1234_5678);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (o_wr_bram_trig !== 1'b1 || o_wr_bram_addr !== 13'h0A5 || o_wr_bram_data !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL single_hold_c%0d: trig=%0b addr=%0h data=%0h, expected 1 0a5 deadbeef",
                         c, o_wr_bram_trig, o_wr_bram_addr, o_wr_bram_data);
            end
            if (c < 3) tick();
        end
        i_wr_bram_ack = 1'b1;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b0 || o_done !== 4'b0100 || o_wr_bram_addr !== '0 || o_wr_bram_data !== '0) begin
            errors++;
            $display("FAIL single_done: trig=%0b done=%b addr=%0h data=%0h, expected 0 0100 0 0",
                     o_wr_bram_trig, o_done, o_wr_bram_addr, o_wr_bram_data);
        end
        i_wr_bram_ack = 1'b0;
        i_req         = '0;
        tick();
        checks++;
        if (o_done !== 4'b0000 || o_busy !== 1'b0 || o_grant_id !== 3'd2) begin
            errors++;
            $display("FAIL single_after: done=%b busy=%0b grant=%0d, expected 0000 0 2", o_done, o_busy, o_grant_id);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        init_words();
        i_req         = 4'b1111;
        i_wr_bram_ack = 1'b1;
        for (int k = 0; k < NUM_REQ; k++)
            serve(k);
        i_wr_bram_ack = 1'b0;
    endtask

    task automatic test_fairness();
        do_reset();
        i_wr_bram_ack = 1'b1;
        i_req[1] = 1'b1;
        serve(1);
        i_req = 4'b0011;
        serve(0);
        i_req[0] = 1'b1;
        serve(1);
        i_req[1] = 1'b1;
        serve(0);
        i_req[0] = 1'b1;
        serve(1);
        i_req         = '0;
        i_wr_bram_ack = 1'b0;
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        i_req = 4'b1000;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b1 || o_grant_id !== 3'd3) begin
            errors++;
            $display("FAIL abort_grant: trig=%0b grant=%0d, expected 1 3", o_wr_bram_trig, o_grant_id);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b0 || o_done !== 4'b0000 || o_busy !== 1'b0 || o_grant_id !== 3'd0) begin
            errors++;
            $display("FAIL abort_reset: trig=%0b done=%b busy=%0b grant=%0d, expected 0 0000 0 0",
                     o_wr_bram_trig, o_done, o_busy, o_grant_id);
        end
        i_rst         = 1'b0;
        i_req         = 4'b1001;
        i_wr_bram_ack = 1'b1;
        serve(0);
        serve(3);
        i_wr_bram_ack = 1'b0;
    endtask

    task automatic test_idle_ack_and_drop();
        i_req         = '0;
        i_wr_bram_ack = 1'b1;
        tick();
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b0 || o_busy !== 1'b0 || o_done !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ack: trig=%0b busy=%0b done=%b, expected 0 0 0000", o_wr_bram_trig, o_busy, o_done);
        end
        i_wr_bram_ack = 1'b0;
        i_req         = 4'b0010;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b1 || o_grant_id !== 3'd1 || o_wr_bram_addr !== 13'h101) begin
            errors++;
            $display("FAIL drop_grant: trig=%0b grant=%0d addr=%0h, expected 1 1 101",
                     o_wr_bram_trig, o_grant_id, o_wr_bram_addr);
        end
        i_req = '0;
        tick();
        checks++;
        if (o_wr_bram_trig !== 1'b1 || o_done !== 4'b0000) begin
            errors++;
            $display("FAIL drop_hold: trig=%0b done=%b, expected 1 0000", o_wr_bram_trig, o_done);
        end
        i_wr_bram_ack = 1'b1;
        tick();
        checks++;
        if (o_done !== 4'b0010 || o_wr_bram_trig !== 1'b0) begin
            errors++;
            $display("FAIL drop_done: done=%b trig=%0b, expected 0010 0", o_done, o_wr_bram_trig);
        end
        i_wr_bram_ack = 1'b0;
        tick();
        checks++;
        if (o_done !== 4'b0000 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL drop_after: done=%b busy=%0b, expected 0000 0", o_done, o_busy);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        i_req = 4'b0100;
        tick();
        n = 0;
        while (o_wr_bram_trig === 1'b1 && n < 20) begin
            n++;
            tick();
        end
`ifdef BRAM_WR_ARB_TIMEOUT_EN
        checks++;
        if (n !== TIMEOUT_CYC) begin
            errors++;
            $display("FAIL timeout_len: trig high %0d cycles, expected %0d", n, TIMEOUT_CYC);
        end
        checks++;
        if (o_done !== 4'b0100 || o_timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: done=%b err=%0b, expected 0100 1", o_done, o_timeout_err);
        end
        i_req = '0;
        tick();
        tick();
        checks++;
        if (o_timeout_err !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_sticky: err=%0b busy=%0b, expected 1 0", o_timeout_err, o_busy);
        end
`else
        checks++;
        if (n !== 20 || o_wr_bram_trig !== 1'b1) begin
            errors++;
            $display("FAIL notimeout_hold: trig high %0d cycles (trig=%0b), expected 20 and still 1", n, o_wr_bram_trig);
        end
        checks++;
        if (o_timeout_err !== 1'b0 || o_done !== 4'b0000) begin
            errors++;
            $display("FAIL notimeout_err: err=%0b done=%b, expected 0 0000", o_timeout_err, o_done);
        end
`endif
        do_reset();
        checks++;
        if (o_timeout_err !== 1'b0 || o_wr_bram_trig !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%0b trig=%0b, expected 0 0", o_timeout_err, o_wr_bram_trig);
        end
    endtask

    initial begin
        i_rst         = 1'b1;
        i_req         = '0;
        i_req_addr    = '0;
        i_req_data    = '0;
        i_wr_bram_ack = 1'b0;
        test_reset();
        test_single_write();
        init_words();
        test_round_robin();
        test_fairness();
        test_reset_mid_issue();
        test_idle_ack_and_drop();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
